// File: rtl/aes_mon_pkg.sv
// Shared types for the AES BIST/data-interface protocol monitor: flag indices,
// FSM state encodings and small vector helpers.
package aes_mon_pkg;

   localparam int NUM_CHK = 8;

   typedef enum logic [2:0] {
      ERR_RST_ACT    = 3'd0,
      ERR_DONE_EARLY = 3'd1,
      ERR_DONE_TMO   = 3'd2,
      ERR_DONE_SPUR  = 3'd3,
      ERR_VLD_OVLP   = 3'd4,
      ERR_BVLD_EARLY = 3'd5,
      ERR_BVLD_TMO   = 3'd6,
      ERR_SR_MISS    = 3'd7
   } err_idx_e;

   typedef enum logic [0:0] {
      D_IDLE = 1'b0,
      D_WAIT = 1'b1
   } done_state_e;

   typedef enum logic [0:0] {
      B_IDLE  = 1'b0,
      B_ARMED = 1'b1
   } bist_state_e;

   function automatic logic [3:0] pop_count(input logic [NUM_CHK-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NUM_CHK; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

   // Lowest index wins when several checks fire in the same cycle.
   function automatic logic [2:0] first_idx(input logic [NUM_CHK-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = NUM_CHK - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/aes_mon_win_timer.sv
// Elapsed-cycle window counter: start loads 1, counting runs until cancel or
// the count passes MAX; stop is classified as early/ok against [MIN, MAX].
module aes_mon_win_timer #(
   parameter int MIN = 14,
   parameter int MAX = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   input  logic cancel,
   output logic early,
   output logic ok,
   output logic tmo
);

   localparam int CW = $clog2(MAX + 2);
   localparam logic [CW-1:0] MIN_C = CW'(MIN);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] cnt;

   // A restart in the same cycle as the end of the previous window takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CW'(1);
      end else if (cancel) begin
         cnt <= '0;
      end else if (cnt != '0 && cnt <= MAX_C) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tmo   = (cnt > MAX_C);
   assign early = stop && (cnt != '0) && (cnt < MIN_C) && !tmo;
   assign ok    = stop && (cnt >= MIN_C) && (cnt <= MAX_C);

endmodule

// File: rtl/aes_bist_protocol_mon.sv
// Passive protocol monitor for the AES core BIST/data handshake with sticky flags,
// a saturating violation counter and irq. Define AES_MON_TRACE_EN for first-violation trace.
module aes_bist_protocol_mon
   import aes_mon_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DONE_MIN = 14,
   parameter int DONE_MAX = 64,
   parameter int BVLD_MIN = 10,
   parameter int BVLD_MAX = 64,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mon_en,
   input  logic              err_clr,
   input  logic              is_bist,
   input  logic              en_lsfr_misr,
   input  logic              d_vld,
   input  logic              done,
   input  logic [DATA_W-1:0] d_out,
   output logic [7:0]        err_flags,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              irq
`ifdef AES_MON_TRACE_EN
   ,
   output logic              trc_vld,
   output logic [2:0]        trc_code,
   output logic [DATA_W-1:0] trc_data
`endif
);

   localparam logic [CNT_W+3:0] CNT_MAX = {4'b0, {CNT_W{1'b1}}};

   done_state_e d_state, d_nxt;
   bist_state_e b_state, b_nxt;
   logic is_bist_q, pend, post_rst;
   logic d_start, d_cancel, d_early, d_ok, d_tmo;
   logic b_start, b_cancel, b_early, b_ok, b_tmo;
   logic bist_rise, bist_fall;
   logic [NUM_CHK-1:0] viol;
   logic [3:0] n_new;
   logic [CNT_W+3:0] cnt_sum;
   logic unused_ok;

   assign bist_rise = is_bist & ~is_bist_q;
   assign bist_fall = ~is_bist & is_bist_q;
   assign unused_ok = d_ok ^ b_ok;

   aes_mon_win_timer #(.MIN(DONE_MIN), .MAX(DONE_MAX)) u_done_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (d_start),
      .stop   (done && (d_state == D_WAIT)),
      .cancel (d_cancel),
      .early  (d_early),
      .ok     (d_ok),
      .tmo    (d_tmo)
   );

   aes_mon_win_timer #(.MIN(BVLD_MIN), .MAX(BVLD_MAX)) u_bist_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (b_start),
      .stop   (d_vld && (b_state == B_ARMED)),
      .cancel (b_cancel),
      .early  (b_early),
      .ok     (b_ok),
      .tmo    (b_tmo)
   );

   // done is resolved before d_vld, so a back-to-back op closes the old window and opens a new one.
   always_comb begin
      d_nxt    = d_state;
      b_nxt    = b_state;
      d_start  = 1'b0;
      d_cancel = 1'b0;
      b_start  = 1'b0;
      b_cancel = 1'b0;
      viol     = '0;
      if (!mon_en) begin
         d_nxt    = D_IDLE;
         b_nxt    = B_IDLE;
         d_cancel = 1'b1;
         b_cancel = 1'b1;
      end else begin
         viol[ERR_RST_ACT] = post_rst & (d_vld | done);
         viol[ERR_SR_MISS] = pend & ~en_lsfr_misr;
         case (d_state)
            D_IDLE: begin
               viol[ERR_DONE_SPUR] = done;
               if (d_vld) begin
                  d_start = 1'b1;
                  d_nxt   = D_WAIT;
               end
            end
            D_WAIT: begin
               if (d_tmo || done) begin
                  viol[ERR_DONE_TMO]   = d_tmo;
                  viol[ERR_DONE_EARLY] = d_early;
                  d_cancel = 1'b1;
                  d_nxt    = D_IDLE;
                  if (d_vld) begin
                     d_start = 1'b1;
                     d_nxt   = D_WAIT;
                  end
               end else begin
                  viol[ERR_VLD_OVLP] = d_vld;
               end
            end
            default: d_nxt = D_IDLE;
         endcase
         case (b_state)
            B_IDLE: begin
               if (bist_rise) begin
                  b_start = 1'b1;
                  b_nxt   = B_ARMED;
               end
            end
            B_ARMED: begin
               if (b_tmo || d_vld || bist_fall) begin
                  viol[ERR_BVLD_TMO]   = b_tmo;
                  viol[ERR_BVLD_EARLY] = b_early;
                  b_cancel = 1'b1;
                  b_nxt    = B_IDLE;
               end
            end
            default: b_nxt = B_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_state   <= D_IDLE;
         b_state   <= B_IDLE;
         is_bist_q <= 1'b0;
         pend      <= 1'b0;
         post_rst  <= 1'b1;
      end else begin
         d_state   <= d_nxt;
         b_state   <= b_nxt;
         is_bist_q <= is_bist;
         pend      <= mon_en & is_bist & ~en_lsfr_misr;
         post_rst  <= 1'b0;
      end
   end

   // A clear in the same cycle as a violation restarts from that violation, not from zero.
   assign n_new   = pop_count(viol);
   assign cnt_sum = (err_clr ? '0 : {4'b0, err_cnt}) + {{CNT_W{1'b0}}, n_new};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flags <= '0;
         err_cnt   <= '0;
         irq       <= 1'b0;
      end else begin
         err_flags <= err_clr ? viol : (err_flags | viol);
         err_cnt   <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
         irq       <= |err_flags;
      end
   end

`ifdef AES_MON_TRACE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trc_vld  <= 1'b0;
         trc_code <= '0;
         trc_data <= '0;
      end else if ((err_clr || !trc_vld) && (|viol)) begin
         trc_vld  <= 1'b1;
         trc_code <= first_idx(viol);
         trc_data <= d_out;
      end else if (err_clr) begin
         trc_vld  <= 1'b0;
         trc_code <= '0;
         trc_data <= '0;
      end
   end
`else
   logic unused_dout;
   assign unused_dout = ^d_out;
`endif

endmodule

// File: doc/aes_bist_protocol_mon.md
Name: aes_bist_protocol_mon

Overview:
Synthesizable, parametrised protocol monitor for the 8-bit AES core's BIST/data interface. It passively samples the core's handshake signals and checks done latency, BIST start-to-valid latency, LFSR/MISR enable coupling and post-reset quiescence. Each violation sets a sticky error flag and increments a saturating counter. It sits beside the AES top and is readable by the AHB wrapper or the bench, in silicon or in simulation.

Parameters:
DATA_W, 8, width of d_out sampled for trace capture
DONE_MIN, 14, min cycles from d_vld to DONE (inclusive)
DONE_MAX, 64, max cycles from d_vld to DONE (inclusive); must be > DONE_MIN
BVLD_MIN, 10, min cycles from is_bist rise to d_vld (inclusive)
BVLD_MAX, 64, max cycles from is_bist rise to d_vld (inclusive)
CNT_W, 8, error counter width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
mon_en  in  1  checks armed when 1; counters and FSMs hold in IDLE when 0
err_clr  in  1  synchronous clear of err_flags and err_cnt
is_bist  in  1  BIST mode request from the AES top
en_lsfr_misr  in  1  LFSR/MISR shift enable
d_vld  in  1  input block valid (start of operation)
done  in  1  core operation complete
d_out  in  DATA_W  core output byte
err_flags  out  8  sticky per-check violation flags
err_cnt  out  CNT_W  saturating total violation count
irq  out  1  OR of err_flags, registered

Behaviour:
- Reset (rst_n=0, async): err_flags=0, err_cnt=0, irq=0, both FSMs in IDLE, latency counters=0, post_rst=1.
- Flag bits: [0] RST_ACT (d_vld or done high on the first sampled edge after reset release), [1] DONE_EARLY, [2] DONE_TMO, [3] DONE_SPUR, [4] VLD_OVLP, [5] BVLD_EARLY, [6] BVLD_TMO, [7] SR_MISS.
- Latency: a flag is set on the clock edge that samples the violation, so it is visible the next cycle. irq follows one cycle later.
- post_rst clears after the first edge. It is independent of mon_en.
- Done FSM, IDLE/WAIT:
  - IDLE, d_vld: go to WAIT with dcnt=1.
  - IDLE, done: DONE_SPUR.
  - WAIT: dcnt increments each cycle.
  - WAIT, done with dcnt<DONE_MIN: DONE_EARLY, go to IDLE.
  - WAIT, done with DONE_MIN<=dcnt<=DONE_MAX: pass, go to IDLE.
  - WAIT, dcnt reaches DONE_MAX+1 without done: DONE_TMO, go to IDLE.
  - WAIT, d_vld without done: VLD_OVLP; the operation keeps running.
  - WAIT, done and d_vld in the same cycle: done is evaluated first, then the new operation starts (WAIT, dcnt=1), with no overlap error.
- BIST FSM, IDLE/ARMED:
  - IDLE, is_bist rising edge (registered prev): go to ARMED with bcnt=1.
  - ARMED, d_vld with bcnt<BVLD_MIN: BVLD_EARLY.
  - ARMED, d_vld with bcnt in window: pass.
  - Every d_vld in ARMED returns the FSM to IDLE.
  - ARMED, bcnt>BVLD_MAX: BVLD_TMO, go to IDLE.
  - is_bist falling while ARMED: cancel silently, go to IDLE.
- SR check: is_bist=1 and en_lsfr_misr=0 at cycle t sets pend. If pend and en_lsfr_misr=0 at t+1: SR_MISS. This matches "enabled same or next cycle".
- Counter: increments by the number of flags newly detected that cycle, clamped at 2^CNT_W-1. Multiple simultaneous violations all set their bits.
- err_clr and a new violation in the same cycle: the new violation wins. Its bit is set and err_cnt loads the new-violation count.
- mon_en=0: FSMs forced to IDLE, pend=0, flags and count hold. Re-enable starts fresh.
- Reset mid-operation: everything returns to reset values immediately. No error is reported for the aborted operation.

Optional Feature:
Macro: AES_MON_TRACE_EN.
- Defined: adds outputs trc_code (3b, index of first violation since clear) and trc_data (DATA_W, d_out sampled in the violating cycle), plus trc_vld. These capture only the first violation and clear on reset or err_clr.
- Undefined: those ports and registers are absent, with no other change.

Decomposition:
- Package aes_mon_pkg holds:
  - the enum for the flag bit indices (ERR_RST_ACT..ERR_SR_MISS);
  - the done FSM state enum {D_IDLE, D_WAIT};
  - the BIST FSM state enum {B_IDLE, B_ARMED};
  - the NUM_CHK=8 constant.
- One sub-module, aes_mon_win_timer: a generic start/stop/cancel window counter with MIN/MAX parameters and early/ok/timeout outputs. It is instantiated twice, for the done check and the BIST check.

Test Plan:
- Legal op: d_vld at cycle 0, done at cycle 20 (defaults) -> err_flags=0x00, err_cnt=0, irq=0.
- Early/late done: done 5 cycles after d_vld -> flags=0x02, cnt=1. Next op with no done for 65 cycles -> flags=0x06, cnt=2, irq=1.
- BIST window: is_bist rises, d_vld after 4 cycles -> bit5. Repeat with d_vld after 12 cycles -> no new flag. en_lsfr_misr held 0 for 2 cycles with is_bist=1 -> bit7.
- Reset: release rst_n with d_vld=1 -> flags=0x01. Assert rst_n mid-WAIT -> all outputs 0 and no DONE_TMO later.
- Simultaneous events: done and d_vld in the same WAIT cycle at dcnt=20 -> no error and a new op is timed. err_clr together with a spurious done -> flags=0x08, cnt=1.
- Saturation (CNT_W=2): 5 spurious dones -> err_cnt stays 3. With AES_MON_TRACE_EN: first violation on d_out=0xA5 gives trc_data=0xA5 and trc_code=3.
